cf_pio_sequencer: RTL and testbench

Host-side initiator for CompactFlash True-IDE 8-bit PIO register cycles. It turns a single-cycle request from the CPU I/O decode logic into a correctly timed CF bus cycle: address/CS setup, then DIOR_n/DIOW_n pulse, then hold and recovery. It honours IORDY wait extension with a timeout and returns read data plus a completion strobe. It sits between the S-100 I/O port decoder and the CF card pins, in the same clock domain as the bus-side flip-flop logic.

---
 rtl/cf_pio_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cf_pio_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cf_pio_sequencer
// Purpose  : Host-side initiator for CompactFlash True-IDE 8-bit PIO register
//            cycles. A single-cycle request from the CPU I/O decoder becomes a
//            timed CF bus cycle: address/CS setup, DIOR_n/DIOW_n pulse with
//            IORDY wait extension and timeout, hold, then recovery. Returns
//            captured read data, a one-cycle done strobe and a timeout flag.
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            req/wr/addr/cs_sel/wdata - request, sampled only while busy=0
//            busy/done/rdata/err   - status and read data back to the CPU side
//            cf_a/cf_cs0_n/cf_cs1_n/cf_dior_n/cf_diow_n/cf_d_out/cf_d_oe
//                                  - registered CF pin drives
//            cf_d_in, cf_iordy     - CF data in and asynchronous ready
// Revision : 1.0 - initial release
// ============================================================================
module cf_pio_sequencer #(
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 9,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 4,
  parameter int IORDY_TO    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic       cs_sel,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic [2:0] cf_a,
  output logic       cf_cs0_n,
  output logic       cf_cs1_n,
  output logic       cf_dior_n,
  output logic       cf_diow_n,
  output logic [7:0] cf_d_out,
  output logic       cf_d_oe,
  input  logic [7:0] cf_d_in,
  input  logic       cf_iordy
);

  // One shared phase counter; size it for the longest phase.
  localparam int c_MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int c_MAX_B   = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int c_MAX_C   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CNT_MAX = (c_MAX_C > IORDY_TO) ? c_MAX_C : IORDY_TO;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_SETUP   = c_CNT_W'(SETUP_CYC);
  localparam logic [c_CNT_W-1:0] c_PULSE   = c_CNT_W'(PULSE_CYC);
  localparam logic [c_CNT_W-1:0] c_HOLD    = c_CNT_W'(HOLD_CYC);
  localparam logic [c_CNT_W-1:0] c_RECOVER = c_CNT_W'(RECOVER_CYC);
  localparam logic [c_CNT_W-1:0] c_TO      = c_CNT_W'(IORDY_TO);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_wr;
  logic               r_iordy_meta;
  logic               r_iordy_s;

  // IORDY comes straight from the card pin; two flops before the FSM sees it.
  // Resetting to 1 means "ready", so no spurious extension right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iordy_meta <= 1'b1;
      r_iordy_s    <= 1'b1;
    end else begin
      r_iordy_meta <= cf_iordy;
      r_iordy_s    <= r_iordy_meta;
    end
  end

  // r_cnt holds the 1-based index of the current cycle within the phase, so
  // each phase ends on the edge where r_cnt equals its length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      err       <= 1'b0;
      cf_a      <= 3'd0;
      cf_cs0_n  <= 1'b1;
      cf_cs1_n  <= 1'b1;
      cf_dior_n <= 1'b1;
      cf_diow_n <= 1'b1;
      cf_d_out  <= 8'h00;
      cf_d_oe   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state  <= S_SETUP;
            r_cnt    <= c_ONE;
            r_wr     <= wr;
            busy     <= 1'b1;
            err      <= 1'b0;
            cf_a     <= addr;
            cf_cs0_n <= cs_sel;
            cf_cs1_n <= ~cs_sel;
            cf_d_oe  <= wr;
            if (wr) begin
              cf_d_out <= wdata;
            end
          end
        end

        S_SETUP: begin
          if (r_cnt == c_SETUP) begin
            r_state <= S_PULSE;
            r_cnt   <= c_ONE;
            if (r_wr) begin
              cf_diow_n <= 1'b0;
            end else begin
              cf_dior_n <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        S_PULSE: begin
          // After the minimum width, end when the card is ready or when the
          // total pulse length reaches the timeout. Ready wins on a tie.
          if ((r_cnt >= c_PULSE) && (r_iordy_s || (r_cnt == c_TO))) begin
            r_state   <= S_HOLD;
            r_cnt     <= c_ONE;
            cf_dior_n <= 1'b1;
            cf_diow_n <= 1'b1;
            err       <= ~r_iordy_s;
            if (!r_wr) begin
              rdata <= cf_d_in;
            end
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        S_HOLD: begin
          if (r_cnt == c_HOLD) begin
            r_state  <= S_RECOVER;
            r_cnt    <= c_ONE;
            cf_cs0_n <= 1'b1;
            cf_cs1_n <= 1'b1;
            cf_d_oe  <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        S_RECOVER: begin
          if (r_cnt == c_RECOVER) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          busy      <= 1'b0;
          cf_cs0_n  <= 1'b1;
          cf_cs1_n  <= 1'b1;
          cf_dior_n <= 1'b1;
          cf_diow_n <= 1'b1;
          cf_d_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cf_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cf_pio_sequencer
// Purpose  : Self-checking bench for cf_pio_sequencer. Expected pin activity
//            is derived per cycle from the phase lengths and the IORDY rise
//            time of each transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cf_pio_sequencer;

  localparam int S  = 4;
  localparam int P  = 9;
  localparam int H  = 2;
  localparam int R  = 4;
  localparam int TO = 64;

  logic       clk;
  logic       reset;
  logic       req;
  logic       wr;
  logic [2:0] addr;
  logic       cs_sel;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       err;
  logic [2:0] cf_a;
  logic       cf_cs0_n;
  logic       cf_cs1_n;
  logic       cf_dior_n;
  logic       cf_diow_n;
  logic [7:0] cf_d_out;
  logic       cf_d_oe;
  logic [7:0] cf_d_in;
  logic       cf_iordy;

  int         total;
  int         bad;
  logic [7:0] m_rdata;  // model of the last captured read data

  cf_pio_sequencer #(
    .SETUP_CYC  (S),
    .PULSE_CYC  (P),
    .HOLD_CYC   (H),
    .RECOVER_CYC(R),
    .IORDY_TO   (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .cs_sel   (cs_sel),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .cf_a     (cf_a),
    .cf_cs0_n (cf_cs0_n),
    .cf_cs1_n (cf_cs1_n),
    .cf_dior_n(cf_dior_n),
    .cf_diow_n(cf_diow_n),
    .cf_d_out (cf_d_out),
    .cf_d_oe  (cf_d_oe),
    .cf_d_in  (cf_d_in),
    .cf_iordy (cf_iordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction. t_rise = 0: IORDY stays high; otherwise IORDY is low
  // from before acceptance and rises at the start of cycle t_rise.
  // ctrl vector = {busy, done, cs0_n, cs1_n, dior_n, diow_n, d_oe}.
  task automatic run_txn(input logic t_wr, input logic [2:0] t_addr,
                         input logic t_cs, input logic [7:0] t_wdata,
                         input logic [7:0] t_din, input int t_rise);
    int         p_nat, p_end, h_end, b_end;
    logic       exp_err, act, stb;
    logic [7:0] exp_rd, e_rd;
    logic [6:0] e_ctrl, a_ctrl;
    // IORDY seen by the FSM two edges after the pin rises
    p_nat = S + P;
    if (t_rise > 0 && t_rise + 2 > p_nat) p_nat = t_rise + 2;
    p_end   = (p_nat > S + TO) ? S + TO : p_nat;
    exp_err = (p_nat > S + TO);
    h_end   = p_end + H;
    b_end   = h_end + R;
    exp_rd  = t_wr ? m_rdata : t_din;

    @(negedge clk);
    req = 1'b1; wr = t_wr; addr = t_addr; cs_sel = t_cs; wdata = t_wdata;
    cf_d_in = t_din;
    cf_iordy = (t_rise > 0) ? 1'b0 : 1'b1;
    @(posedge clk);
    #1;
    // Scramble request fields: they must have been latched at acceptance.
    req = 1'b0; wr = 1'($urandom); addr = 3'($urandom); cs_sel = 1'($urandom);
    wdata = 8'($urandom);
    for (int c = 1; c <= b_end + 1; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (t_rise > 0 && c == t_rise) cf_iordy = 1'b1;
      act    = (c <= h_end);
      stb    = (c > S) && (c <= p_end);
      e_ctrl = {(c <= b_end), (c == h_end + 1), !(act && !t_cs), !(act && t_cs),
                !(stb && !t_wr), !(stb && t_wr), (act && t_wr)};
      a_ctrl = {busy, done, cf_cs0_n, cf_cs1_n, cf_dior_n, cf_diow_n, cf_d_oe};
      total++;
      if (a_ctrl !== e_ctrl) begin
        bad++;
        $display("FAIL ctrl cycle=%0d got=%b want=%b (wr=%0d rise=%0d)",
                 c, a_ctrl, e_ctrl, t_wr, t_rise);
      end
      if (act) begin
        total++;
        if (cf_a !== t_addr) begin
          bad++;
          $display("FAIL cf_a cycle=%0d got=%0d want=%0d", c, cf_a, t_addr);
        end
      end
      if (act && t_wr) begin
        total++;
        if (cf_d_out !== t_wdata) begin
          bad++;
          $display("FAIL cf_d_out cycle=%0d got=%h want=%h", c, cf_d_out, t_wdata);
        end
      end
      e_rd = (c <= p_end) ? m_rdata : exp_rd;
      total++;
      if (rdata !== e_rd) begin
        bad++;
        $display("FAIL rdata cycle=%0d got=%h want=%h", c, rdata, e_rd);
      end
      total++;
      if (err !== ((c <= p_end) ? 1'b0 : exp_err)) begin
        bad++;
        $display("FAIL err cycle=%0d got=%b want=%b", c, err,
                 (c <= p_end) ? 1'b0 : exp_err);
      end
    end
    cf_iordy = 1'b1;
    m_rdata  = exp_rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 3'd0; cs_sel = 1'b0;
    wdata = 8'h00; cf_d_in = 8'h00; cf_iordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, rdata, err, cf_a, cf_cs0_n, cf_cs1_n, cf_dior_n, cf_diow_n,
         cf_d_out, cf_d_oe} !== {1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'b1111, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got busy=%b done=%b rdata=%h err=%b a=%0d cs=%b%b strb=%b%b dout=%h oe=%b want all idle",
               busy, done, rdata, err, cf_a, cf_cs0_n, cf_cs1_n, cf_dior_n,
               cf_diow_n, cf_d_out, cf_d_oe);
    end
    @(negedge clk);
    reset = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic test_reset_mid_pulse();
    // Give rdata a nonzero value first so the reset clearing it is visible.
    run_txn(1'b0, 3'd1, 1'b0, 8'h00, 8'hA5, 0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 3'd6; cs_sel = 1'b1; wdata = 8'h3C;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    total++;
    if (cf_diow_n !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_strobe got=%b want=0", cf_diow_n);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({cf_cs0_n, cf_cs1_n, cf_dior_n, cf_diow_n, cf_d_oe, busy, rdata, err}
        !== {5'b11110, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got cs=%b%b strb=%b%b oe=%b busy=%b rdata=%h err=%b want 1111 0 0 00 0",
               cf_cs0_n, cf_cs1_n, cf_dior_n, cf_diow_n, cf_d_oe, busy, rdata, err);
    end
    @(negedge clk);
    reset = 1'b0;
    m_rdata = 8'h00;
    run_txn(1'b1, 3'd2, 1'b0, 8'h81, 8'h00, 0);
  endtask

  task automatic test_write();
    run_txn(1'b1, 3'd7, 1'b0, 8'hEC, 8'h11, 0);
  endtask

  task automatic test_read();
    run_txn(1'b0, 3'd7, 1'b0, 8'h00, 8'h50, 0);
  endtask

  task automatic test_iordy_extend();
    run_txn(1'b0, 3'd3, 1'b1, 8'h00, 8'h9E, 20);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'd4, 1'b0, 8'h00, 8'h77, 1000);
    run_txn(1'b1, 3'd5, 1'b1, 8'h42, 8'h00, 0);  // err must clear
  endtask

  task automatic test_random();
    int kind, rise;
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)      rise = 0;
      else if (kind == 1) rise = $urandom_range(2, S + P + 10);
      else                rise = $urandom_range(S + TO - 4, S + TO + 4);
      run_txn(1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom),
              8'($urandom), rise);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d2;
    logic [7:0] e_rd;
    logic [6:0] e_ctrl, a_ctrl;
    logic       cs1_lo, b;
    d2 = 8'($urandom) ^ 8'h5A;
    if (d2 == m_rdata) d2 = ~d2;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 3'd3; cs_sel = 1'b1; wdata = 8'hC3;
    cf_iordy = 1'b1; cf_d_in = ~d2;
    @(posedge clk);
    #1;
    wr = 1'b0; addr = 3'd5;  // second request: read, still on CS1
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 20) cf_d_in = d2;
      if (c == 21) req = 1'b0;
      cs1_lo = (c <= 15) || (c >= 21 && c <= 35);
      b      = (c != 20) && (c != 40);
      e_ctrl = {b, (c == 16 || c == 36), 1'b1, !cs1_lo,
                !(c >= 25 && c <= 33), !(c >= 5 && c <= 13), (c <= 15)};
      a_ctrl = {busy, done, cf_cs0_n, cf_cs1_n, cf_dior_n, cf_diow_n, cf_d_oe};
      total++;
      if (a_ctrl !== e_ctrl) begin
        bad++;
        $display("FAIL b2b_ctrl cycle=%0d got=%b want=%b", c, a_ctrl, e_ctrl);
      end
      e_rd = (c <= 33) ? m_rdata : d2;
      total++;
      if (rdata !== e_rd) begin
        bad++;
        $display("FAIL b2b_rdata cycle=%0d got=%h want=%h", c, rdata, e_rd);
      end
      if (cs1_lo) begin
        total++;
        if (cf_a !== ((c <= 15) ? 3'd3 : 3'd5)) begin
          bad++;
          $display("FAIL b2b_addr cycle=%0d got=%0d want=%0d", c, cf_a,
                   (c <= 15) ? 3'd3 : 3'd5);
        end
      end
    end
    m_rdata = d2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_rdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_iordy_extend();
    test_timeout();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
